// File: rtl/barrett_2237_pkg.sv
// barrett_2237_pkg: constants and residue type for the mod-2237 Barrett reducer.
package barrett_2237_pkg;
  localparam int unsigned Q = 2237;
  localparam int unsigned K = 12;
  localparam int unsigned M = 7499;
  localparam int unsigned IN_W = 23;
  localparam int unsigned Q1_W = 12;
  localparam int unsigned Q2_W = 25;
  localparam int unsigned R_W = 14;
  typedef logic [K-1:0] residue_t;
endpackage

// File: rtl/barrett_for_2237_if.sv
// barrett_for_2237_if: operand in / residue out bundle for the reducer.
interface barrett_for_2237_if;
  import barrett_2237_pkg::*;
  logic [IN_W-1:0] din_a;
  residue_t dout_r;
  modport master (output din_a, input dout_r);
  modport slave (input din_a, output dout_r);
endinterface

// File: rtl/barrett_2237_core.sv
// barrett_2237_core: combinational x mod 2237 via Barrett estimate and two corrections.
module barrett_2237_core
  import barrett_2237_pkg::*;
(
  input  logic [IN_W-1:0] x,
  output residue_t        r
);
  logic [Q1_W-1:0] q1;
  logic [Q2_W-1:0] q2;
  logic [Q1_W-1:0] q3;
  logic [IN_W-1:0] q3q;
  logic [R_W-1:0] r0, r1;
  always_comb begin
    q1 = x[IN_W-1:K-1];
    q2 = Q2_W'(q1) * Q2_W'(M);
    q3 = Q1_W'(q2 >> (K + 1));
    q3q = IN_W'(q3) * IN_W'(Q);
    // estimate undershoots by at most 2Q, so r0 fits in 14 bits
    r0 = R_W'(x - q3q);
    r1 = (r0 >= R_W'(Q)) ? r0 - R_W'(Q) : r0;
    r = K'((r1 >= R_W'(Q)) ? r1 - R_W'(Q) : r1);
  end
endmodule

// File: rtl/barrett_for_2237.sv
// barrett_for_2237: registered mod-2237 reducer, one result per clock, latency 1.
module barrett_for_2237
  import barrett_2237_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  barrett_for_2237_if.slave     bus
);
  residue_t res, dout_d, dout_q;
  barrett_2237_core u_core (.x(bus.din_a), .r(res));
  always_comb dout_d = rst ? '0 : res;
  always_ff @(posedge clk) dout_q <= dout_d;
  assign bus.dout_r = dout_q;
endmodule

// File: tb/tb_barrett_for_2237.sv
// tb_barrett_for_2237: directed table, sweep, random stream and reset checks.
module tb_barrett_for_2237;
  logic clk = 0;
  logic rst = 1;
  int n_run = 0;
  int n_fail = 0;
  bit armed = 0;
  barrett_for_2237_if bus ();
  barrett_for_2237 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [22:0] x;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[12];
  always @(negedge clk)
    if (armed) assert (bus.dout_r < 12'd2237) else $error("range violation %0d", bus.dout_r);
  task automatic apply(input string name, input logic [22:0] x, input logic r, input logic [11:0] exp);
    @(negedge clk);
    bus.din_a = x;
    rst = r;
    @(posedge clk);
    #1;
    n_run++;
    if (bus.dout_r !== exp) begin
      n_fail++;
      $display("FAIL %s: x=%0d got %0d expected %0d", name, x, bus.dout_r, exp);
    end
  endtask
  initial begin
    logic [22:0] x;
    vecs[0] = '{23'd0, 12'd0};
    vecs[1] = '{23'd5, 12'd5};
    vecs[2] = '{23'd2236, 12'd2236};
    vecs[3] = '{23'd2237, 12'd0};
    vecs[4] = '{23'd2238, 12'd1};
    vecs[5] = '{23'd4473, 12'd2236};
    vecs[6] = '{23'd4474, 12'd0};
    vecs[7] = '{23'd6710, 12'd2236};
    vecs[8] = '{23'd12345, 12'd1160};
    vecs[9] = '{23'd1000000, 12'd61};
    vecs[10] = '{23'd5004168, 12'd2236};
    vecs[11] = '{23'd8388607, 12'd2094};
    bus.din_a = 23'd4000;
    apply("reset0", 23'd4000, 1'b1, 12'd0);
    apply("reset1", 23'd8388607, 1'b1, 12'd0);
    armed = 1;
    apply("first_after_reset", 23'd5, 1'b0, 12'd5);
    for (int i = 0; i < 12; i++) apply("table", vecs[i].x, 1'b0, vecs[i].exp);
    for (int i = 0; i < 2237; i++) apply("sweep", 23'(i), 1'b0, 12'(i));
    for (int i = 0; i < 20000; i++) begin
      x = 23'($urandom);
      apply("random", x, 1'b0, 12'(x % 23'd2237));
    end
    for (int i = 0; i < 5; i++) begin
      x = 23'($urandom);
      apply("pre_rst", x, 1'b0, 12'(x % 23'd2237));
    end
    apply("mid_rst", 23'd8388000, 1'b1, 12'd0);
    x = 23'($urandom);
    apply("post_rst", x, 1'b0, 12'(x % 23'd2237));
    apply("post_rst_fixed", 23'd4473, 1'b0, 12'd2236);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
